output_arbiter: RTL and testbench

Shares the byte-wide host output block between two result producers: the scalar reduction-return path and the vector-return buffer. Arbitrates round-robin at packet boundaries, prefixes each packet with a one-byte tag, serializes 32-bit words little-endian into the output block, and honours output-block backpressure. Sits between the reduction ALU / vector output buffer and the output block, downstream of the top control FSM.

---
 rtl/vec_accel_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 35 +++
 rtl/output_arbiter.sv | 118 +++++++++++
 tb/tb_output_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_accel_pkg.sv
// Shared types and defaults for the vector accelerator result path.
package vec_accel_pkg;

    localparam int         DATA_W_DEF   = 32;
    localparam logic [7:0] TAG_SCAL_DEF = 8'h01;
    localparam logic [7:0] TAG_VEC_DEF  = 8'h02;

    // Serializer states of output_arbiter.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TAG   = 2'd1,
        ST_BYTES = 2'd2,
        ST_NEXT  = 2'd3
    } oa_state_e;

    // Result producers sharing the output block.
    typedef enum logic {
        SRC_SCAL = 1'b0,
        SRC_VEC  = 1'b1
    } src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: scalar on req[0], vector on req[1].
// Grant is combinational and one-hot; on a tie it goes to the source
// not granted last. The last-grant register moves only on advance.
module rr_arb2
    import vec_accel_pkg::*;
(
    input  logic       clk,
    input  logic       rst_l,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    src_e last_grant;

    // Pick a single winner; a tie favours whoever lost last time.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = (last_grant == SRC_VEC) ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

    // Remember the winner when the consumer commits to the grant.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            last_grant <= SRC_VEC;
        end else if (advance && (grant != 2'b00)) begin
            last_grant <= grant[1] ? SRC_VEC : SRC_SCAL;
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// Shares the byte-wide output block between the scalar return path and
// the vector return buffer. Each packet is a tag byte followed by the
// result words, least significant byte first.
//
// Handshakes:
//   scal_req is a level held with stable scal_data until scal_ack, which
//   pulses in the cycle the last byte of the word is written.
//   vec_valid qualifies vec_data/vec_last; vec_pop pulses in the cycle the
//   last byte of the element is written, after which the source presents
//   the next element. output_blk_full high means no byte is taken this
//   cycle; set_output_blk is never asserted while it is high.
module output_arbiter
    import vec_accel_pkg::*;
#(
    parameter int         DATA_W   = DATA_W_DEF,
    parameter logic [7:0] TAG_SCAL = TAG_SCAL_DEF,
    parameter logic [7:0] TAG_VEC  = TAG_VEC_DEF
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              scal_req,
    input  logic [DATA_W-1:0] scal_data,
    output logic              scal_ack,
    input  logic              vec_valid,
    input  logic [DATA_W-1:0] vec_data,
    input  logic              vec_last,
    output logic              vec_pop,
    input  logic              output_blk_full,
    output logic [7:0]        out_byte,
    output logic              set_output_blk,
    output logic              busy,
    output oa_state_e         fsm_state
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

    oa_state_e         state;
    src_e              src;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        grant;
    logic              write;
    logic              last_byte;
    logic [DATA_W-1:0] word;

    // Arbitration is only consulted between packets.
    rr_arb2 u_arb (
        .clk     (clk),
        .rst_l   (rst_l),
        .req     ({vec_valid, scal_req}),
        .advance (state == ST_IDLE),
        .grant   (grant)
    );

    assign write     = ((state == ST_TAG) || (state == ST_BYTES)) && !output_blk_full;
    assign last_byte = write && (state == ST_BYTES) && (cnt == CNT_LAST);
    assign word      = (src == SRC_SCAL) ? scal_data : vec_data;

    assign set_output_blk = write;
    assign scal_ack       = last_byte && (src == SRC_SCAL);
    assign vec_pop        = last_byte && (src == SRC_VEC);
    assign busy           = (state != ST_IDLE);
    assign fsm_state      = state;

    // Byte presented to the output block; source words are read live.
    always_comb begin
        out_byte = 8'h00;
        case (state)
            ST_TAG:   out_byte = (src == SRC_SCAL) ? TAG_SCAL : TAG_VEC;
            ST_BYTES: out_byte = word[{cnt, 3'b000} +: 8];
            default:  out_byte = 8'h00;
        endcase
    end

    // Serializer: grant latch, tag, bytes, and vector element hand-over.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= ST_IDLE;
            src   <= SRC_VEC;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        src   <= grant[0] ? SRC_SCAL : SRC_VEC;
                        state <= ST_TAG;
                    end
                end
                ST_TAG: begin
                    if (write) begin
                        state <= ST_BYTES;
                        cnt   <= '0;
                    end
                end
                ST_BYTES: begin
                    if (write) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= ((src == SRC_VEC) && !vec_last) ? ST_NEXT : ST_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_NEXT: begin
                    // Grant is held: only the vector source can continue.
                    if (vec_valid) begin
                        state <= ST_BYTES;
                        cnt   <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_arbiter.sv
// Bench for output_arbiter: queue-backed source models, a packet-level
// reference model producing the expected byte stream, and a scoreboard.
module tb_output_arbiter;
    import vec_accel_pkg::*;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } elem_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_l = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        scal_req = 1'b0;
    logic [31:0] scal_data = '0;
    logic        scal_ack;
    logic        vec_valid = 1'b0;
    logic [31:0] vec_data = '0;
    logic        vec_last = 1'b0;
    logic        vec_pop;
    logic        output_blk_full = 1'b0;
    logic [7:0]  out_byte;
    logic        set_output_blk;
    logic        busy;
    oa_state_e   fsm_state;

    output_arbiter dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .scal_req        (scal_req),
        .scal_data       (scal_data),
        .scal_ack        (scal_ack),
        .vec_valid       (vec_valid),
        .vec_data        (vec_data),
        .vec_last        (vec_last),
        .vec_pop         (vec_pop),
        .output_blk_full (output_blk_full),
        .out_byte        (out_byte),
        .set_output_blk  (set_output_blk),
        .busy            (busy),
        .fsm_state       (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0]  exp_q[$];
    logic [31:0] scal_q[$];
    elem_t       vec_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int wr_count = 0, ack_count = 0, pop_count = 0;
    int first_wr_cyc = -1, ack_cyc = -1, req_cyc = 0;
    int stall_at = -1, stall_left = 0;
    bit scal_adv = 0, vec_adv = 0, rand_full = 0;
    bit model_last_vec = 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        else n_pass++;
    endtask

    // ---------------- reference model ----------------
    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'((w >> (8 * i)) & 32'hFF));
    endtask

    // Everything queued is pending at once: ties alternate, starting
    // from whichever source did not win last.
    task automatic build_expected();
        logic [31:0] s[$];
        elem_t       v[$];
        elem_t       e;
        s = scal_q;
        v = vec_q;
        while (s.size() > 0 || v.size() > 0) begin
            if (s.size() > 0 && (v.size() == 0 || model_last_vec)) begin
                exp_q.push_back(8'h01);
                push_word(s.pop_front());
                model_last_vec = 0;
            end else begin
                exp_q.push_back(8'h02);
                do begin
                    e = v.pop_front();
                    push_word(e.d);
                end while (!e.last && v.size() > 0);
                model_last_vec = 1;
            end
        end
    endtask

    task automatic add_vec_pkt(input int n);
        for (int i = 0; i < n; i++) vec_q.push_back('{d: $urandom(), last: (i == n - 1)});
    endtask

    // ---------------- driver: inputs change just after posedge ----------------
    always @(posedge clk) begin
        #1;
        if (!rst_l) begin
            scal_adv        = 0;
            vec_adv         = 0;
            stall_left      = 0;
            output_blk_full = 1'b0;
        end else begin
            if (scal_adv && scal_q.size() > 0) scal_q.delete(0);
            if (vec_adv && vec_q.size() > 0) vec_q.delete(0);
            scal_adv = 0;
            vec_adv  = 0;
            if (stall_left > 0) begin
                output_blk_full = 1'b1;
                stall_left--;
            end else begin
                output_blk_full = rand_full && ($urandom_range(0, 3) == 0);
            end
        end
        if (scal_q.size() > 0 && !scal_req) req_cyc = cyc;
        scal_req  = (scal_q.size() > 0);
        scal_data = scal_req ? scal_q[0] : 32'h0;
        vec_valid = (vec_q.size() > 0);
        vec_data  = vec_valid ? vec_q[0].d : 32'h0;
        vec_last  = vec_valid ? vec_q[0].last : 1'b0;
    end

    // ---------------- monitor: outputs sampled at negedge ----------------
    always @(negedge clk) begin
        if (rst_l) begin
            if (output_blk_full) check("wr_while_full", set_output_blk, 1'b0);
            if (set_output_blk) begin
                wr_count++;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                check("byte_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("out_byte", out_byte, exp_q.pop_front());
                if (wr_count == stall_at) stall_left = 3;
            end
            if (scal_ack) begin
                ack_count++;
                ack_cyc = cyc;
                check("ack_with_strobe", set_output_blk, 1'b1);
                scal_adv = 1;
            end
            if (vec_pop) begin
                pop_count++;
                check("pop_with_strobe", set_output_blk, 1'b1);
                vec_adv = 1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_test();
        wr_count     = 0;
        ack_count    = 0;
        pop_count    = 0;
        first_wr_cyc = -1;
        ack_cyc      = -1;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((scal_q.size() > 0 || vec_q.size() > 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check("done_in_budget", 32'(n < budget), 1);
        repeat (2) tick();
        check("exp_drained", exp_q.size(), 0);
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n = 0;
        while (wr_count < target && n < budget) begin
            tick();
            n++;
        end
        check("writes_in_budget", 32'(n < budget), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] w;
        int ns, ne, np, k;

        #1 rst_l = 1'b0;
        #2;
        check("rst_scal_ack", scal_ack, 1'b0);
        check("rst_vec_pop", vec_pop, 1'b0);
        check("rst_set_output_blk", set_output_blk, 1'b0);
        check("rst_out_byte", out_byte, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_state_idle", 32'(fsm_state == ST_IDLE), 1);

        // Both sources pending from reset: scalar, vector, scalar, vector.
        scal_q.push_back($urandom());
        scal_q.push_back($urandom());
        add_vec_pkt(2);
        add_vec_pkt(3);
        build_expected();
        start_test();
        repeat (2) @(posedge clk);
        #2 rst_l = 1'b1;
        wait_done(500);
        check("tie_acks", ack_count, 2);
        check("tie_pops", pop_count, 5);
        check("tie_writes", wr_count, 2 * 5 + 2 + 5 * 4);

        // Nothing pending: stays idle.
        repeat (3) tick();
        check("idle_busy", busy, 1'b0);
        check("idle_strobe", set_output_blk, 1'b0);

        // Scalar alone, no backpressure.
        start_test();
        scal_q.push_back(32'hDEADBEEF);
        exp_q = {8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        model_last_vec = 0;
        wait_done(100);
        check("scal_tag_latency", first_wr_cyc - req_cyc, 1);
        check("scal_ack_latency", ack_cyc - req_cyc, 5);
        check("scal_writes", wr_count, 5);
        check("scal_acks", ack_count, 1);

        // Three-element vector packet, one tag only.
        start_test();
        vec_q.push_back('{d: 32'h03020100, last: 1'b0});
        vec_q.push_back('{d: 32'h07060504, last: 1'b0});
        vec_q.push_back('{d: 32'h0B0A0908, last: 1'b1});
        exp_q.push_back(8'h02);
        for (int i = 0; i < 12; i++) exp_q.push_back(8'(i));
        model_last_vec = 1;
        wait_done(200);
        check("vec_pops", pop_count, 3);
        check("vec_writes", wr_count, 13);
        check("vec_acks", ack_count, 0);

        // Scalar with three full cycles after its first data byte.
        start_test();
        stall_at = 2;
        scal_q.push_back($urandom());
        build_expected();
        wait_done(200);
        stall_at = -1;
        check("stall_latency", ack_cyc - first_wr_cyc, 7);
        check("stall_writes", wr_count, 5);

        // Scalar arriving mid-way through a four-element vector packet.
        start_test();
        add_vec_pkt(4);
        build_expected();
        wait_writes(7, 200);
        w = $urandom();
        scal_q.push_back(w);
        exp_q.push_back(8'h01);
        push_word(w);
        model_last_vec = 0;
        wait_done(300);
        check("mid_pkt_pops", pop_count, 4);
        check("mid_pkt_acks", ack_count, 1);
        check("mid_pkt_writes", wr_count, 17 + 5);

        // Reset during a scalar packet; the packet restarts from its tag.
        start_test();
        scal_q.push_back($urandom());
        build_expected();
        wait_writes(4, 100);
        rst_l = 1'b0;
        #1;
        check("mid_rst_strobe", set_output_blk, 1'b0);
        check("mid_rst_out_byte", out_byte, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ack", scal_ack, 1'b0);
        check("mid_rst_acks_so_far", ack_count, 0);
        exp_q.delete();
        model_last_vec = 1;
        build_expected();
        start_test();
        repeat (2) tick();
        rst_l = 1'b1;
        wait_done(200);
        check("rst_restart_writes", wr_count, 5);
        check("rst_restart_acks", ack_count, 1);

        // Random mixes with random backpressure.
        rand_full = 1;
        for (int r = 0; r < 8; r++) begin
            start_test();
            ns = $urandom_range(0, 3);
            np = $urandom_range(0, 3);
            ne = 0;
            for (int i = 0; i < ns; i++) scal_q.push_back($urandom());
            for (int i = 0; i < np; i++) begin
                k = $urandom_range(1, 4);
                add_vec_pkt(k);
                ne += k;
            end
            build_expected();
            wait_done(3000);
            check("rand_acks", ack_count, ns);
            check("rand_pops", pop_count, ne);
        end
        rand_full = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
